// File: rtl/dscope_pkg.sv
// Shared types and widths for the defectoscope
// slot sequencer and per-channel pulser.
package dscope_pkg;

  localparam int TS_W   = 16;
  localparam int HIT_W  = 8;
  localparam int CNT_W  = 4;
  localparam int HUSH_W = 16;
  localparam int MASK_W = 4;
  localparam int NSLOT  = 4;

  localparam int DEAD_TICKS_DEF = 1;

  typedef enum logic [2:0] {
    CH_IDLE,
    CH_HIT,
    CH_DH,
    CH_GND,
    CH_DG,
    CH_HUSH,
    CH_RX
  } chan_st_e;

  typedef enum logic {
    SQ_IDLE,
    SQ_RUN
  } seq_st_e;

  typedef struct packed {
    logic [MASK_W-1:0] mask;
    logic [HIT_W-1:0]  hit;
    logic [HIT_W-1:0]  gnd;
    logic [CNT_W-1:0]  cnt;
    logic [HUSH_W-1:0] hush;
  } chan_cfg_t;

  // Last tick index of a slot; zero length acts as one.
  function automatic logic [TS_W-1:0] slot_last(
    input logic [TS_W-1:0] ts
  );
    return (ts == '0) ? '0 : ts - 1'b1;
  endfunction

endpackage

// File: rtl/pulse_chan.sv
// One pulser channel: latches its slot parameters and
// runs HIT/DH/GND/DG x count, then HUSH, then RX.
// Ports: i_start (slot strobe, latch + launch),
//   i_clr (slot ends / sequencer stops, abort),
//   i_cfg (slot parameters), o_hit/o_gnd (bridge
//   drive), o_hush (blanking), o_rx (receive window).
module pulse_chan
  import dscope_pkg::*;
#(
  parameter int DEAD_TICKS = DEAD_TICKS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              i_clr,
  input  chan_cfg_t         i_cfg,
  output logic [MASK_W-1:0] o_hit,
  output logic [MASK_W-1:0] o_gnd,
  output logic              o_hush,
  output logic              o_rx
);

  localparam logic [HIT_W-1:0] DEAD_M1 =
    HIT_W'(DEAD_TICKS - 1);

  chan_st_e          r_st;
  chan_cfg_t         r_cfg;
  logic [HIT_W-1:0]  r_ph;
  logic [CNT_W-1:0]  r_pl;
  logic [HUSH_W-1:0] r_hc;
  logic [MASK_W-1:0] r_hit;
  logic [MASK_W-1:0] r_gnd;
  logic              r_hush;
  logic              r_rx;

  chan_st_e          w_st;
  chan_cfg_t         w_cfg;
  logic [HIT_W-1:0]  w_ph;
  logic [CNT_W-1:0]  w_pl;
  logic [HUSH_W-1:0] w_hc;
  logic              w_pend;
  logic              w_train;
  logic              w_hush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= CH_IDLE;
      r_cfg  <= '0;
      r_ph   <= '0;
      r_pl   <= '0;
      r_hc   <= '0;
      r_hit  <= '0;
      r_gnd  <= '0;
      r_hush <= 1'b0;
      r_rx   <= 1'b0;
    end else begin
      r_st   <= w_st;
      r_cfg  <= w_cfg;
      r_ph   <= w_ph;
      r_pl   <= w_pl;
      r_hc   <= w_hc;
      r_hit  <= (w_st == CH_HIT) ? w_cfg.mask : '0;
      r_gnd  <= (w_st == CH_GND) ? w_cfg.mask : '0;
      r_hush <= (w_st == CH_HUSH);
      r_rx   <= (w_st == CH_RX);
    end
  end

  // w_pend: one hit/gnd pulse has just finished.
  // w_train: (re)start a pulse; w_hush: train done.
  always_comb begin
    w_st    = r_st;
    w_cfg   = r_cfg;
    w_ph    = r_ph;
    w_pl    = r_pl;
    w_hc    = r_hc;
    w_pend  = 1'b0;
    w_train = 1'b0;
    w_hush  = 1'b0;
    if (i_clr) begin
      w_st = CH_IDLE;
    end else if (i_start) begin
      w_cfg = i_cfg;
      if (i_cfg.cnt == '0 ||
          (i_cfg.hit == '0 && i_cfg.gnd == '0)) begin
        w_hush = 1'b1;
      end else begin
        w_pl    = i_cfg.cnt - 1'b1;
        w_train = 1'b1;
      end
    end else begin
      unique case (r_st)
        CH_HIT: begin
          if (r_ph == '0) begin
            w_st = CH_DH;
            w_ph = DEAD_M1;
          end else begin
            w_ph = r_ph - 1'b1;
          end
        end
        CH_DH: begin
          if (r_ph != '0) begin
            w_ph = r_ph - 1'b1;
          end else if (r_cfg.gnd != '0) begin
            w_st = CH_GND;
            w_ph = r_cfg.gnd - 1'b1;
          end else begin
            w_pend = 1'b1;
          end
        end
        CH_GND: begin
          if (r_ph == '0) begin
            w_st = CH_DG;
            w_ph = DEAD_M1;
          end else begin
            w_ph = r_ph - 1'b1;
          end
        end
        CH_DG: begin
          if (r_ph == '0) begin
            w_pend = 1'b1;
          end else begin
            w_ph = r_ph - 1'b1;
          end
        end
        CH_HUSH: begin
          if (r_hc == '0) begin
            w_st = CH_RX;
          end else begin
            w_hc = r_hc - 1'b1;
          end
        end
        default: ;
      endcase
      if (w_pend) begin
        if (r_pl == '0) begin
          w_hush = 1'b1;
        end else begin
          w_pl    = r_pl - 1'b1;
          w_train = 1'b1;
        end
      end
    end
    if (w_train) begin
      if (w_cfg.hit != '0) begin
        w_st = CH_HIT;
        w_ph = w_cfg.hit - 1'b1;
      end else begin
        w_st = CH_GND;
        w_ph = w_cfg.gnd - 1'b1;
      end
    end
    if (w_hush) begin
      if (w_cfg.hush == '0) begin
        w_st = CH_RX;
      end else begin
        w_st = CH_HUSH;
        w_hc = w_cfg.hush - 1'b1;
      end
    end
  end

  assign o_hit  = r_hit;
  assign o_gnd  = r_gnd;
  assign o_hush = r_hush;
  assign o_rx   = r_rx;

endmodule

// File: rtl/slot_pulser.sv
// Slot sequencer (slot 0..3, per-slot tick length)
// driving four pulse_chan channels.
// Ports: i_enable run request; o_slot to the table,
//   o_slot_start/o_frame_start strobes; i_ts_time_N
//   slot lengths; i_pulse_*_N channel N parameters;
//   o_hit/o_gnd/o_hush/o_rx_N channel N outputs.
module slot_pulser
  import dscope_pkg::*;
#(
  parameter int DEAD_TICKS = DEAD_TICKS_DEF,
  parameter int NCH        = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  output logic [1:0]        o_slot,
  output logic              o_slot_start,
  output logic              o_frame_start,
  input  logic [TS_W-1:0]   i_ts_time_0,
  input  logic [TS_W-1:0]   i_ts_time_1,
  input  logic [TS_W-1:0]   i_ts_time_2,
  input  logic [TS_W-1:0]   i_ts_time_3,
  input  logic [MASK_W-1:0] i_pulse_mask_0,
  input  logic [MASK_W-1:0] i_pulse_mask_1,
  input  logic [MASK_W-1:0] i_pulse_mask_2,
  input  logic [MASK_W-1:0] i_pulse_mask_3,
  input  logic [HIT_W-1:0]  i_pulse_hit_0,
  input  logic [HIT_W-1:0]  i_pulse_hit_1,
  input  logic [HIT_W-1:0]  i_pulse_hit_2,
  input  logic [HIT_W-1:0]  i_pulse_hit_3,
  input  logic [HIT_W-1:0]  i_pulse_gnd_0,
  input  logic [HIT_W-1:0]  i_pulse_gnd_1,
  input  logic [HIT_W-1:0]  i_pulse_gnd_2,
  input  logic [HIT_W-1:0]  i_pulse_gnd_3,
  input  logic [CNT_W-1:0]  i_pulse_count_0,
  input  logic [CNT_W-1:0]  i_pulse_count_1,
  input  logic [CNT_W-1:0]  i_pulse_count_2,
  input  logic [CNT_W-1:0]  i_pulse_count_3,
  input  logic [HUSH_W-1:0] i_pulse_hush_0,
  input  logic [HUSH_W-1:0] i_pulse_hush_1,
  input  logic [HUSH_W-1:0] i_pulse_hush_2,
  input  logic [HUSH_W-1:0] i_pulse_hush_3,
  output logic [MASK_W-1:0] o_hit_0,
  output logic [MASK_W-1:0] o_hit_1,
  output logic [MASK_W-1:0] o_hit_2,
  output logic [MASK_W-1:0] o_hit_3,
  output logic [MASK_W-1:0] o_gnd_0,
  output logic [MASK_W-1:0] o_gnd_1,
  output logic [MASK_W-1:0] o_gnd_2,
  output logic [MASK_W-1:0] o_gnd_3,
  output logic              o_hush_0,
  output logic              o_hush_1,
  output logic              o_hush_2,
  output logic              o_hush_3,
  output logic              o_rx_0,
  output logic              o_rx_1,
  output logic              o_rx_2,
  output logic              o_rx_3
);

  seq_st_e         r_sst;
  logic [1:0]      r_slot;
  logic [TS_W-1:0] r_tc;
  logic            r_ss;
  logic            r_fs;

  seq_st_e         w_sst;
  logic [1:0]      w_slot;
  logic [TS_W-1:0] w_tc;
  logic            w_ss;
  logic            w_end;
  logic [TS_W-1:0] w_ts;
  logic [TS_W-1:0] w_ts_tab [NSLOT];

  chan_cfg_t         w_cfg  [NCH];
  logic [MASK_W-1:0] w_hit  [NCH];
  logic [MASK_W-1:0] w_gnd  [NCH];
  logic              w_hush [NCH];
  logic              w_rx   [NCH];

  assign w_ts_tab[0] = i_ts_time_0;
  assign w_ts_tab[1] = i_ts_time_1;
  assign w_ts_tab[2] = i_ts_time_2;
  assign w_ts_tab[3] = i_ts_time_3;

  assign w_cfg[0] = '{i_pulse_mask_0, i_pulse_hit_0,
    i_pulse_gnd_0, i_pulse_count_0, i_pulse_hush_0};
  assign w_cfg[1] = '{i_pulse_mask_1, i_pulse_hit_1,
    i_pulse_gnd_1, i_pulse_count_1, i_pulse_hush_1};
  assign w_cfg[2] = '{i_pulse_mask_2, i_pulse_hit_2,
    i_pulse_gnd_2, i_pulse_count_2, i_pulse_hush_2};
  assign w_cfg[3] = '{i_pulse_mask_3, i_pulse_hit_3,
    i_pulse_gnd_3, i_pulse_count_3, i_pulse_hush_3};

  assign w_ts  = w_ts_tab[r_slot];
  assign w_end = (r_sst == SQ_RUN) &&
                 (r_tc == slot_last(w_ts));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sst  <= SQ_IDLE;
      r_slot <= '0;
      r_tc   <= '0;
      r_ss   <= 1'b0;
      r_fs   <= 1'b0;
    end else begin
      r_sst  <= w_sst;
      r_slot <= w_slot;
      r_tc   <= w_tc;
      r_ss   <= w_ss;
      r_fs   <= w_ss && (w_slot == 2'd0);
    end
  end

  always_comb begin
    w_sst  = r_sst;
    w_slot = r_slot;
    w_tc   = r_tc + 1'b1;
    w_ss   = 1'b0;
    unique case (r_sst)
      SQ_IDLE: begin
        w_tc = '0;
        if (i_enable) begin
          w_sst  = SQ_RUN;
          w_slot = 2'd0;
          w_ss   = 1'b1;
        end
      end
      SQ_RUN: begin
        if (w_end) begin
          w_tc = '0;
          if (i_enable) begin
            w_slot = r_slot + 2'd1;
            w_ss   = 1'b1;
          end else begin
            w_sst  = SQ_IDLE;
            w_slot = 2'd0;
          end
        end
      end
      default: ;
    endcase
  end

  // Every slot end (advance or stop) aborts the
  // channels, so drives are off in the strobe cycle.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    pulse_chan #(
      .DEAD_TICKS(DEAD_TICKS)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (r_ss),
      .i_clr   (w_end),
      .i_cfg   (w_cfg[k]),
      .o_hit   (w_hit[k]),
      .o_gnd   (w_gnd[k]),
      .o_hush  (w_hush[k]),
      .o_rx    (w_rx[k])
    );
  end

  assign o_slot        = r_slot;
  assign o_slot_start  = r_ss;
  assign o_frame_start = r_fs;

  assign o_hit_0  = w_hit[0];
  assign o_hit_1  = w_hit[1];
  assign o_hit_2  = w_hit[2];
  assign o_hit_3  = w_hit[3];
  assign o_gnd_0  = w_gnd[0];
  assign o_gnd_1  = w_gnd[1];
  assign o_gnd_2  = w_gnd[2];
  assign o_gnd_3  = w_gnd[3];
  assign o_hush_0 = w_hush[0];
  assign o_hush_1 = w_hush[1];
  assign o_hush_2 = w_hush[2];
  assign o_hush_3 = w_hush[3];
  assign o_rx_0   = w_rx[0];
  assign o_rx_1   = w_rx[1];
  assign o_rx_2   = w_rx[2];
  assign o_rx_3   = w_rx[3];

endmodule

// File: tb/tb_slot_pulser.sv
// Bench for slot_pulser: directed frames, overrun,
// zero lengths, random tables/enable, async reset.
module tb_slot_pulser;
  import dscope_pkg::*;

  localparam int D = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  logic [15:0] tb_ts [4];
  chan_cfg_t   tb_tab [4][4];
  chan_cfg_t   c_in [4];

  logic [1:0] o_slot;
  logic       o_ss;
  logic       o_fs;
  logic [3:0] o_hit [4];
  logic [3:0] o_gnd [4];
  logic       o_hush [4];
  logic       o_rx [4];

  int n_cmp = 0;
  int n_bad = 0;

  logic       m_on;
  logic [1:0] m_slot;
  int         m_age;
  chan_cfg_t  m_cfg [4];
  bit         g_rnd;

  always #5 clk = ~clk;

  always_comb
    for (int k = 0; k < 4; k++)
      c_in[k] = tb_tab[m_slot][k];

  slot_pulser #(
    .DEAD_TICKS(D),
    .NCH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(en),
    .o_slot(o_slot), .o_slot_start(o_ss),
    .o_frame_start(o_fs),
    .i_ts_time_0(tb_ts[0]), .i_ts_time_1(tb_ts[1]),
    .i_ts_time_2(tb_ts[2]), .i_ts_time_3(tb_ts[3]),
    .i_pulse_mask_0(c_in[0].mask),
    .i_pulse_mask_1(c_in[1].mask),
    .i_pulse_mask_2(c_in[2].mask),
    .i_pulse_mask_3(c_in[3].mask),
    .i_pulse_hit_0(c_in[0].hit),
    .i_pulse_hit_1(c_in[1].hit),
    .i_pulse_hit_2(c_in[2].hit),
    .i_pulse_hit_3(c_in[3].hit),
    .i_pulse_gnd_0(c_in[0].gnd),
    .i_pulse_gnd_1(c_in[1].gnd),
    .i_pulse_gnd_2(c_in[2].gnd),
    .i_pulse_gnd_3(c_in[3].gnd),
    .i_pulse_count_0(c_in[0].cnt),
    .i_pulse_count_1(c_in[1].cnt),
    .i_pulse_count_2(c_in[2].cnt),
    .i_pulse_count_3(c_in[3].cnt),
    .i_pulse_hush_0(c_in[0].hush),
    .i_pulse_hush_1(c_in[1].hush),
    .i_pulse_hush_2(c_in[2].hush),
    .i_pulse_hush_3(c_in[3].hush),
    .o_hit_0(o_hit[0]), .o_hit_1(o_hit[1]),
    .o_hit_2(o_hit[2]), .o_hit_3(o_hit[3]),
    .o_gnd_0(o_gnd[0]), .o_gnd_1(o_gnd[1]),
    .o_gnd_2(o_gnd[2]), .o_gnd_3(o_gnd[3]),
    .o_hush_0(o_hush[0]), .o_hush_1(o_hush[1]),
    .o_hush_2(o_hush[2]), .o_hush_3(o_hush[3]),
    .o_rx_0(o_rx[0]), .o_rx_1(o_rx[1]),
    .o_rx_2(o_rx[2]), .o_rx_3(o_rx[3])
  );

  task automatic chk(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic chan_cfg_t mk(
    int m, int h, int g, int c, int u);
    chan_cfg_t r;
    r.mask = 4'(m);
    r.hit  = 8'(h);
    r.gnd  = 8'(g);
    r.cnt  = 4'(c);
    r.hush = 16'(u);
    return r;
  endfunction

  function automatic chan_cfg_t rnd_cfg();
    chan_cfg_t r;
    r.mask = 4'($urandom());
    r.hit  = ($urandom_range(0, 3) == 0) ? 8'd0 :
             8'($urandom_range(1, 12));
    r.gnd  = ($urandom_range(0, 3) == 0) ? 8'd0 :
             8'($urandom_range(1, 12));
    r.cnt  = 4'($urandom_range(0, 5));
    r.hush = ($urandom_range(0, 3) == 0) ? 16'd0 :
             16'($urandom_range(1, 30));
    return r;
  endfunction

  function automatic logic [15:0] rnd_ts();
    int s;
    s = int'($urandom_range(0, 9));
    if (s == 0) return 16'd0;
    if (s == 1) return 16'd1;
    return 16'($urandom_range(5, 150));
  endfunction

  // Expected {hit,gnd,hush,rx} a ticks after strobe:
  // n pulses of period (hit+D)+(gnd+D), then hush,
  // then receive.
  function automatic logic [9:0] exp_ch(
    chan_cfg_t c, int a);
    int h, g, n, u, p, t, off;
    h = int'(c.hit);
    g = int'(c.gnd);
    n = int'(c.cnt);
    u = int'(c.hush);
    if (h == 0 && g == 0) n = 0;
    p = (h > 0 ? h + D : 0) + (g > 0 ? g + D : 0);
    t = a - 1;
    if (t < n * p) begin
      off = t % p;
      if (h > 0) begin
        if (off < h) return {c.mask, 4'b0, 2'b0};
        off = off - h - D;
      end
      if (off >= 0 && off < g)
        return {4'b0, c.mask, 2'b0};
      return '0;
    end
    t = t - n * p;
    return (t < u) ? 10'b10 : 10'b01;
  endfunction

  task automatic model_upd();
    int len;
    if (m_on && m_age == 0)
      for (int k = 0; k < 4; k++)
        m_cfg[k] = tb_tab[m_slot][k];
    if (!m_on) begin
      if (en) begin
        m_on   = 1'b1;
        m_slot = 2'd0;
        m_age  = 0;
      end
    end else begin
      len = (tb_ts[m_slot] == 0) ? 1 :
            int'(tb_ts[m_slot]);
      if (m_age == len - 1) begin
        m_age = 0;
        if (en) begin
          m_slot = m_slot + 2'd1;
        end else begin
          m_on   = 1'b0;
          m_slot = 2'd0;
        end
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic compare();
    logic       st;
    logic [9:0] e;
    st = m_on && m_age == 0;
    chk("slot", int'(o_slot), int'(m_slot));
    chk("slot_start", int'(o_ss), int'(st));
    chk("frame_start", int'(o_fs),
        int'(st && m_slot == 2'd0));
    for (int k = 0; k < 4; k++) begin
      e = (m_on && m_age > 0) ?
          exp_ch(m_cfg[k], m_age) : '0;
      chk($sformatf("hit%0d", k),
          int'(o_hit[k]), int'(e[9:6]));
      chk($sformatf("gnd%0d", k),
          int'(o_gnd[k]), int'(e[5:2]));
      chk($sformatf("hush%0d", k),
          int'(o_hush[k]), int'(e[1]));
      chk($sformatf("rx%0d", k),
          int'(o_rx[k]), int'(e[0]));
      chk($sformatf("overlap%0d", k),
          int'(o_hit[k] & o_gnd[k]), 0);
    end
  endtask

  task automatic stim();
    int s;
    if ($urandom_range(0, 149) == 0) en = ~en;
    if ($urandom_range(0, 19) == 0)
      tb_tab[$urandom_range(0, 3)]
            [$urandom_range(0, 3)] = rnd_cfg();
    if ($urandom_range(0, 59) == 0) begin
      s = int'($urandom_range(0, 3));
      if (2'(s) != m_slot) tb_ts[s] = rnd_ts();
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_upd();
    @(negedge clk);
    compare();
    if (g_rnd) stim();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic go_idle();
    int n;
    n = 0;
    en = 1'b0;
    while (m_on && n < 5000) begin
      cyc();
      n++;
    end
    if (m_on) chk("idle_timeout", 1, 0);
  endtask

  task automatic set_plan();
    tb_ts[0] = 16'd1200;
    tb_ts[1] = 16'd1200;
    tb_ts[2] = 16'd1200;
    tb_ts[3] = 16'd800;
    for (int s = 0; s < 4; s++) begin
      tb_tab[s][0] = mk(1, 10, 10, 4, 40);
      tb_tab[s][1] = mk(6, 5, 5, 0, 0);
      tb_tab[s][2] = mk(5, 0, 7, 3, 12);
      tb_tab[s][3] = mk(8, 2, 18, 1, 0);
    end
  endtask

  initial begin
    int n;
    g_rnd  = 1'b0;
    m_on   = 1'b0;
    m_slot = 2'd0;
    m_age  = 0;
    for (int k = 0; k < 4; k++) m_cfg[k] = '0;
    set_plan();
    en    = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    run(3);

    // Full frame 1200/1200/1200/800 and wrap.
    en = 1'b1;
    run(4500);

    // Overrun: 50-tick slots shorter than train.
    go_idle();
    for (int s = 0; s < 4; s++) tb_ts[s] = 16'd50;
    en = 1'b1;
    run(400);

    // Zero and one tick slots.
    go_idle();
    tb_ts[0] = 16'd0;
    tb_ts[1] = 16'd0;
    tb_ts[2] = 16'd30;
    tb_ts[3] = 16'd1;
    en = 1'b1;
    run(200);

    // Random tables, slot lengths and enable.
    go_idle();
    for (int s = 0; s < 4; s++) begin
      tb_ts[s] = rnd_ts();
      for (int k = 0; k < 4; k++)
        tb_tab[s][k] = rnd_cfg();
    end
    en    = 1'b1;
    g_rnd = 1'b1;
    run(12000);
    g_rnd = 1'b0;

    // Async reset in the middle of a HIT phase.
    go_idle();
    set_plan();
    en = 1'b1;
    n  = 0;
    while (!(m_on && m_age == 5) && n < 50) begin
      cyc();
      n++;
    end
    if (!(m_on && m_age == 5)) chk("hit_wait", 1, 0);
    chk("pre_rst_hit0", int'(o_hit[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_hit0", int'(o_hit[0]), 0);
    chk("rst_gnd3", int'(o_gnd[3]), 0);
    chk("rst_slot_start", int'(o_ss), 0);
    m_on   = 1'b0;
    m_slot = 2'd0;
    m_age  = 0;
    en     = 1'b0;
    @(negedge clk);
    compare();
    rst_n = 1'b1;
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/slot_pulser.md
Name: slot_pulser

Overview:
- Time-slot sequencer and pulser-driver for the 4-channel defectoscope front end.
- Cycles slot 0..3 and drives o_slot to the slot-indexed parameter table, which returns per-channel parameters for that slot.
- Per channel, generates the excitation pulse train (hit/gnd bridge drive gated by mask), the post-pulse hush (blanking) window and the receive window consumed by the ADC capture stage.
- Sits directly downstream of the parameter table and upstream of the transducer drivers and ADC capture.

Parameters:
- DEAD_TICKS, 1, all-off cycles inserted after every HIT and every GND phase (shoot-through guard); legal range 1..15.
- NCH, 4, channel count; fixed at 4 and not otherwise supported.

Ports:
- clk  in  1  system clock (200 ticks = 1 us).
- rst_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  run request.
- o_slot  out  2  current slot index to the parameter table; registered.
- o_slot_start  out  1  one-cycle strobe in the first cycle of each slot.
- o_frame_start  out  1  o_slot_start qualified by o_slot==0.
- i_ts_time_0..3  in  16 each  length of slot 0..3 in ticks.
- i_pulse_mask_0..3  in  4 each  per-channel output-line mask for the current slot.
- i_pulse_hit_0..3  in  8 each  HIT phase length in ticks.
- i_pulse_gnd_0..3  in  8 each  GND phase length in ticks.
- i_pulse_count_0..3  in  4 each  number of hit/gnd pulses.
- i_pulse_hush_0..3  in  16 each  blanking length in ticks.
- o_hit_0..3  out  4 each  high-side drive (= latched mask while in HIT, else 0).
- o_gnd_0..3  out  4 each  low-side drive (= latched mask while in GND, else 0).
- o_hush_0..3  out  1 each  blanking active.
- o_rx_0..3  out  1 each  receive window active.

Behaviour:
- Reset, asynchronous: o_slot=0, all strobes and drives 0, sequencer and channels IDLE, all counters 0.
- Sequencer states are IDLE and RUN.
  - IDLE with i_enable=1 at edge E: after E, state=RUN, o_slot=0, o_slot_start=1, tick counter=0.
  - RUN: counter increments each cycle. When counter == max(ts_time[o_slot],1)-1, o_slot advances (3 wraps to 0), o_slot_start pulses and the counter clears.
  - Slot length is exactly max(ts_time,1) cycles. ts_time of 0 is treated as 1.
  - Frame length = sum of the four slot lengths.
- i_enable low while in RUN: the current slot completes. At its end the sequencer enters IDLE instead of advancing, with o_slot=0 and no strobe. All channels abort to IDLE, so all drives are 0 from that cycle.
- Parameter capture:
  - The table is combinational on o_slot. Because o_slot is registered, parameters are valid during the o_slot_start cycle.
  - Each channel latches mask, hit, gnd, count and hush on that cycle. Input changes at other times are ignored.
- Channel FSM states: IDLE, HIT, DH, GND, DG, HUSH, RX.
  - With start cycle T: HIT holds for hit ticks, then DH for DEAD_TICKS, then GND for gnd ticks, then DG for DEAD_TICKS. This repeats count times.
  - After the last DG: HUSH for hush ticks, then RX until the next o_slot_start or until the sequencer goes IDLE.
- Zero-value rules:
  - count=0: go directly to HUSH.
  - hit=0: skip HIT and DH.
  - gnd=0: skip GND and DG.
  - hit=0 and gnd=0 with count>0: behaves as count=0.
  - hush=0: go directly to RX.
- Invariant: o_hit_k & o_gnd_k == 0 at all times. Every HIT-to-GND transition passes through at least DEAD_TICKS all-off cycles.
- o_slot_start while a channel is in any state (train overrun): abort immediately. Drives are 0 in the strobe cycle and the new train begins at T+1 with the new parameters.
- Outputs are registered; drives change on the clock edge only.
- Counter widths: 8 bits for phase, 4 bits for pulse, 16 bits for hush and slot; no overflow is possible.

Decomposition:
- Shared package dscope_pkg holds:
  - the channel state enum;
  - width constants TS_W=16, HIT_W=8, CNT_W=4, HUSH_W=16, MASK_W=4;
  - the default DEAD_TICKS.
- One sub-module, pulse_chan, contains a single channel's latch and FSM. slot_pulser instantiates it 4 times alongside the sequencer.

Test Plan:
- Reset, then i_enable=1 with ts_time 1200/1200/1200/800: o_slot_start at cycles 0, 1200, 2400, 3600 and 4400; o_frame_start at 0 and 4400; o_slot sequence 0,1,2,3,0.
- Channel 0 with mask=0001, hit=10, gnd=10, count=4, hush=40, DEAD=1, start at T: o_hit=0001 at T+1..T+10; off at T+11; o_gnd=0001 at T+12..T+21; 4 pulses end at T+88; o_hush at T+89..T+128; o_rx from T+129 to the end of the slot.
- Channel 3 with hit=2, gnd=18, count=1, hush=0: hit T+1..T+2, gnd T+4..T+21, rx from T+23; hit and gnd never overlap.
- Overrun with ts_time=50 and the train above: the train aborts at the slot boundary, drives are 0 in the strobe cycle, and the new train starts at T+1.
- count=0 and hush=0: o_rx=1 from T+1; ts_time=0 gives a 1-cycle slot with consecutive strobes.
- i_enable dropped mid-slot: the slot completes, then IDLE with all outputs 0. Reset asserted mid-HIT: o_hit goes to 0 asynchronously.
